// File: rtl/hamming_secded_decoder.sv
// Purpose: pipelined extended-Hamming SEC-DED decoder with saturating error-event counters.
// Latency: a word driven before edge k is captured in S1 at edge k and appears on the outputs after edge k+1.
// Backpressure: valid/ready on both sides; outputs hold while out_ready=0, S1 then fills and in_ready drops.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, d_hamm[0:N] codeword (bit 0 = overall parity)
//   out_valid/out_ready  output handshake, d_disp[1:K] data, syndrome, err_corr, err_uncorr
//   cnt_clr              clears both counters (wins over a coincident increment)
//   cnt_corr/cnt_uncorr  saturating counts of delivered corrected / uncorrectable words
module hamming_secded_decoder #(
  parameter int R     = 3,
  parameter int CNT_W = 8,
  localparam int N    = (1 << R) - 1,
  localparam int K    = N - R
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:N]       d_hamm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:K]       d_disp,
  output logic [R-1:0]     syndrome,
  output logic             err_corr,
  output logic             err_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  logic           s1_valid;
  logic [0:N]     s1_word;
  logic           s2_valid;
  logic           s2_ready;

  logic [R-1:0]   syn_c;
  logic           p_all_c;
  logic [1:N]     fixed_c;
  logic [1:K]     data_c;
  logic           corr_c;
  logic           uncorr_c;

  assign s2_ready  = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s2_ready;
  assign out_valid = s2_valid;

  // Decode of the word sitting in S1.
  always_comb begin
    int k;
    syn_c   = '0;
    p_all_c = s1_word[0];
    for (int i = 1; i <= N; i++) begin
      p_all_c = p_all_c ^ s1_word[i];
      if (s1_word[i]) syn_c = syn_c ^ R'(i);
    end

    // Only a nonzero syndrome with odd overall parity points at a bit to flip;
    // s=0 with odd parity means bit 0 itself was hit and the data is intact.
    fixed_c = s1_word[1:N];
    if ((syn_c != '0) && p_all_c) fixed_c[syn_c] = ~fixed_c[syn_c];

    corr_c   = p_all_c;
    uncorr_c = (syn_c != '0) && !p_all_c;

    // Data bits are the non-power-of-two positions, packed in ascending order.
    data_c = '0;
    k      = 1;
    for (int i = 1; i <= N; i++) begin
      if ((i & (i - 1)) != 0) begin
        data_c[k] = fixed_c[i];
        k         = k + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_word    <= '0;
      s2_valid   <= 1'b0;
      d_disp     <= '0;
      syndrome   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else begin
      // S2 takes whatever S1 holds whenever it is empty or being drained;
      // payload only moves with a real word so a stall never disturbs it.
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          d_disp     <= data_c;
          syndrome   <= syn_c;
          err_corr   <= corr_c;
          err_uncorr <= uncorr_c;
        end
      end

      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_word <= d_hamm;
      end

      if (cnt_clr) begin
        cnt_corr   <= '0;
        cnt_uncorr <= '0;
      end else if (s2_valid && out_ready) begin
        if (err_corr && (cnt_corr != '1))     cnt_corr   <= cnt_corr + 1'b1;
        if (err_uncorr && (cnt_uncorr != '1)) cnt_uncorr <= cnt_uncorr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Purpose: directed self-checking bench for hamming_secded_decoder (R=3, CNT_W=8 and CNT_W=2).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: exercises a 4-cycle out_ready stall during a 6-word stream.
module tb_hamming_secded_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:7] d_hamm;
  logic       out_ready;
  logic       cnt_clr;

  logic       in_ready,  out_valid,  err_corr,  err_uncorr;
  logic [1:4] d_disp;
  logic [2:0] syndrome;
  logic [7:0] cnt_corr, cnt_uncorr;

  logic       in_ready2, out_valid2, err_corr2, err_uncorr2;
  logic [1:4] d_disp2;
  logic [2:0] syndrome2;
  logic [1:0] cnt_corr2, cnt_uncorr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_secded_decoder #(.R(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d_hamm(d_hamm),
    .out_valid(out_valid), .out_ready(out_ready), .d_disp(d_disp), .syndrome(syndrome),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .cnt_clr(cnt_clr),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  hamming_secded_decoder #(.R(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .d_hamm(d_hamm),
    .out_valid(out_valid2), .out_ready(out_ready), .d_disp(d_disp2), .syndrome(syndrome2),
    .err_corr(err_corr2), .err_uncorr(err_uncorr2), .cnt_clr(cnt_clr),
    .cnt_corr(cnt_corr2), .cnt_uncorr(cnt_uncorr2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word with out_ready high: not visible after the first edge,
  // visible after the second, counters updated after the third (the handshake edge).
  task automatic send_one(input logic [0:7] w, input logic [1:4] exp_d, input logic [2:0] exp_s,
                          input logic exp_c, input logic exp_u, input int exp_cc, input int exp_cu);
    in_valid = 1'b1;
    d_hamm   = w;
    tick();
    in_valid = 1'b0;
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("d_disp",    {28'd0, d_disp},    {28'd0, exp_d});
    check("syndrome",  {29'd0, syndrome},  {29'd0, exp_s});
    check("err_corr",  {31'd0, err_corr},  {31'd0, exp_c});
    check("err_uncorr",{31'd0, err_uncorr},{31'd0, exp_u});
    tick();
    check("cnt_corr",   {24'd0, cnt_corr},   exp_cc);
    check("cnt_uncorr", {24'd0, cnt_uncorr}, exp_cu);
  endtask

  logic [0:7] s_word [6];
  logic [6:0] s_exp  [6];   // {data[1:4], syndrome}

  initial begin
    int sent;
    int rcvd;
    int stalled;
    int saw_in_ready_low;
    logic [6:0] held;

    s_word[0] = 8'b0_0110011; s_exp[0] = {4'b1011, 3'd0};
    s_word[1] = 8'b0_0100011; s_exp[1] = {4'b1011, 3'd3};
    s_word[2] = 8'b0_0000000; s_exp[2] = {4'b0000, 3'd0};
    s_word[3] = 8'b1_1111111; s_exp[3] = {4'b1111, 3'd0};
    s_word[4] = 8'b0_0100111; s_exp[4] = {4'b0111, 3'd6};
    s_word[5] = 8'b1_0110011; s_exp[5] = {4'b1011, 3'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    d_hamm    = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_d_disp",     {28'd0, d_disp},     32'd0);
    check("rst_syndrome",   {29'd0, syndrome},   32'd0);
    check("rst_err_corr",   {31'd0, err_corr},   32'd0);
    check("rst_err_uncorr", {31'd0, err_uncorr}, 32'd0);
    check("rst_cnt_corr",   {24'd0, cnt_corr},   32'd0);
    check("rst_cnt_uncorr", {24'd0, cnt_uncorr}, 32'd0);
    check("rst_in_ready",   {31'd0, in_ready},   32'd1);

    // Directed decode vectors
    out_ready = 1'b1;
    send_one(8'b0_0110011, 4'b1011, 3'd0, 1'b0, 1'b0, 0, 0);  // clean
    send_one(8'b0_0100011, 4'b1011, 3'd3, 1'b1, 1'b0, 1, 0);  // pos 3 flipped
    send_one(8'b1_0110011, 4'b1011, 3'd0, 1'b1, 1'b0, 2, 0);  // bit 0 flipped
    send_one(8'b0_0100111, 4'b0111, 3'd6, 1'b0, 1'b1, 2, 1);  // pos 3 and 5 flipped

    // Six-word stream with out_ready low in cycles 3..6
    sent = 0; rcvd = 0; stalled = 0; saw_in_ready_low = 0; held = '0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 6);
      d_hamm    = (sent < 6) ? s_word[sent] : 8'd0;
      #1;
      if (!in_ready) saw_in_ready_low = 1;
      if (stalled != 0) check("stall_hold", {25'd0, d_disp, syndrome}, {25'd0, held});
      if (out_valid && out_ready) begin
        check("stream_word", {25'd0, d_disp, syndrome}, {25'd0, s_exp[rcvd]});
        rcvd++;
      end
      stalled = (out_valid && !out_ready) ? 1 : 0;
      held    = {d_disp, syndrome};
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", rcvd, 32'd6);
    check("stream_in_ready_dropped", saw_in_ready_low, 32'd1);

    // Saturation on the CNT_W=2 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_cnt_start", {30'd0, cnt_corr2}, 32'd0);
    in_valid = 1'b1;
    d_hamm   = 8'b0_0100011;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("sat_cnt_corr2", {30'd0, cnt_corr2}, 32'd3);
    check("sat_cnt_corr8", {24'd0, cnt_corr},  32'd5);

    // Sixth word: clear lands on the same edge as its handshake
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("clr_out_valid", {31'd0, out_valid2}, 32'd1);
    check("clr_err_corr",  {31'd0, err_corr2},  32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt_corr2", {30'd0, cnt_corr2}, 32'd0);
    check("clr_cnt_corr8", {24'd0, cnt_corr},  32'd0);

    // Reset with two words in flight
    send_one(8'b0_0100011, 4'b1011, 3'd3, 1'b1, 1'b0, 1, 0);
    in_valid = 1'b1;
    d_hamm   = 8'b0_0100111;
    tick();
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("inflight_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst2_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst2_cnt_corr",   {24'd0, cnt_corr},   32'd0);
    check("rst2_cnt_uncorr", {24'd0, cnt_uncorr}, 32'd0);
    check("rst2_d_disp",     {28'd0, d_disp},     32'd0);
    check("rst2_err_uncorr", {31'd0, err_uncorr}, 32'd0);
    tick();
    check("rst2_in_ready",   {31'd0, in_ready},   32'd1);
    check("rst2_no_ghost",   {31'd0, out_valid},  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
